// File: rtl/img_buffer_loader.sv
// Fetches one image from the bridge into an on-chip pixel buffer, then streams it
// to the MAC in order; a registered random-access port reads the same buffer.
module img_buffer_loader #(
  parameter int INTERFACE_WIDTH_BITS = 128,
  parameter int INTERFACE_ADDR_BITS  = 26,
  parameter int PIXEL_BITS           = 8,
  parameter int NUM_PIXELS           = 784,
  parameter int TIMEOUT_CYCLES       = 4096,
  localparam int PPB       = INTERFACE_WIDTH_BITS / PIXEL_BITS,
  localparam int NUM_BEATS = (NUM_PIXELS + PPB - 1) / PPB,
  localparam int IDX_BITS  = $clog2(NUM_PIXELS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              restream,
  input  logic [INTERFACE_ADDR_BITS-1:0]    base_address,
  output logic [INTERFACE_ADDR_BITS-1:0]    interface_address,
  output logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable,
  output logic                              interface_read,
  input  logic                              interface_acknowledge,
  input  logic [INTERFACE_WIDTH_BITS-1:0]   interface_read_data,
  output logic                              pix_valid,
  input  logic                              pix_ready,
  output logic [PIXEL_BITS-1:0]             pix_data,
  output logic [IDX_BITS-1:0]               pix_index,
  output logic                              pix_last,
  input  logic [IDX_BITS-1:0]               rd_addr,
  output logic [PIXEL_BITS-1:0]             rd_data,
  output logic                              busy,
  output logic                              load_done,
  output logic                              stream_done,
  output logic                              error
);

  localparam int BYTES_PER_BEAT = INTERFACE_WIDTH_BITS / 8;
  localparam int BEAT_BITS      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int SLOT_BITS      = $clog2(NUM_BEATS * PPB + 1);
  localparam int WAIT_BITS      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INTERFACE_ADDR_BITS-1:0] BEAT_STRIDE = INTERFACE_ADDR_BITS'(BYTES_PER_BEAT);
  localparam logic [BEAT_BITS-1:0]           LAST_BEAT   = BEAT_BITS'(NUM_BEATS - 1);
  localparam logic [IDX_BITS-1:0]            LAST_IDX    = IDX_BITS'(NUM_PIXELS - 1);
  localparam logic [WAIT_BITS-1:0]           LAST_WAIT   = WAIT_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM
  } state_t;

  state_t                         state_q, state_d;
  logic [BEAT_BITS-1:0]           beat_q, beat_d;
  logic [INTERFACE_ADDR_BITS-1:0] addr_q, addr_d;
  logic                           read_q, read_d;
  logic [WAIT_BITS-1:0]           wait_q, wait_d;
  logic                           error_q, error_d;
  logic                           image_valid_q, image_valid_d;
  logic                           pix_valid_q, pix_valid_d;
  logic [IDX_BITS-1:0]            pix_index_q, pix_index_d;
  logic                           load_done_q, load_done_d;
  logic                           stream_done_q, stream_done_d;
  logic [PIXEL_BITS-1:0]          rd_data_q, rd_data_d;

  logic [PIXEL_BITS-1:0] buffer_mem [NUM_PIXELS];

  logic                 beat_ack;
  logic [PPB-1:0]       lane_we;
  logic [SLOT_BITS-1:0] lane_slot [PPB];
  logic [IDX_BITS-1:0]  lane_idx  [PPB];

  assign beat_ack = (state_q == ST_LOAD) && read_q && interface_acknowledge;

  // Lanes of the final beat that fall past the image end are dropped.
  always_comb begin
    lane_we = '0;
    for (int j = 0; j < PPB; j++) begin
      lane_slot[j] = SLOT_BITS'(beat_q) * SLOT_BITS'(PPB) + SLOT_BITS'(j);
      lane_idx[j]  = IDX_BITS'(lane_slot[j]);
      lane_we[j]   = beat_ack && (lane_slot[j] < SLOT_BITS'(NUM_PIXELS));
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < PPB; j++) begin
      if (lane_we[j]) begin
        buffer_mem[lane_idx[j]] <= interface_read_data[j*PIXEL_BITS +: PIXEL_BITS];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    addr_d        = addr_q;
    read_d        = read_q;
    wait_d        = wait_q;
    error_d       = error_q;
    image_valid_d = image_valid_q;
    pix_valid_d   = pix_valid_q;
    pix_index_d   = pix_index_q;
    load_done_d   = 1'b0;
    stream_done_d = 1'b0;
    rd_data_d     = (rd_addr <= LAST_IDX) ? buffer_mem[rd_addr] : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_LOAD;
          beat_d        = '0;
          addr_d        = base_address;
          read_d        = 1'b1;
          wait_d        = '0;
          error_d       = 1'b0;
          image_valid_d = 1'b0;
        end else if (restream && image_valid_q) begin
          state_d     = ST_STREAM;
          pix_index_d = '0;
        end
      end

      // A read stays asserted with a stable address until acknowledged; the
      // one-cycle gap after each beat re-arms the request and its wait counter.
      ST_LOAD: begin
        if (!read_q) begin
          read_d = 1'b1;
          wait_d = '0;
        end else if (interface_acknowledge) begin
          read_d = 1'b0;
          if (beat_q == LAST_BEAT) begin
            load_done_d   = 1'b1;
            image_valid_d = 1'b1;
            pix_index_d   = '0;
            state_d       = ST_STREAM;
          end else begin
            beat_d = beat_q + BEAT_BITS'(1);
            addr_d = addr_q + BEAT_STRIDE;
          end
        end else if (wait_q == LAST_WAIT) begin
          read_d        = 1'b0;
          error_d       = 1'b1;
          image_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_BITS'(1);
        end
      end

      ST_STREAM: begin
        if (!pix_valid_q) begin
          pix_valid_d = 1'b1;
        end else if (pix_ready) begin
          if (pix_index_q == LAST_IDX) begin
            stream_done_d = 1'b1;
            pix_valid_d   = 1'b0;
            pix_index_d   = '0;
            state_d       = ST_IDLE;
          end else begin
            pix_index_d = pix_index_q + IDX_BITS'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      addr_q        <= '0;
      read_q        <= 1'b0;
      wait_q        <= '0;
      error_q       <= 1'b0;
      image_valid_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_index_q   <= '0;
      load_done_q   <= 1'b0;
      stream_done_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      addr_q        <= addr_d;
      read_q        <= read_d;
      wait_q        <= wait_d;
      error_q       <= error_d;
      image_valid_q <= image_valid_d;
      pix_valid_q   <= pix_valid_d;
      pix_index_q   <= pix_index_d;
      load_done_q   <= load_done_d;
      stream_done_q <= stream_done_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign interface_address     = addr_q;
  assign interface_byte_enable = '1;
  assign interface_read        = read_q;
  assign pix_valid             = pix_valid_q;
  assign pix_data              = buffer_mem[pix_index_q];
  assign pix_index             = pix_index_q;
  assign pix_last              = pix_valid_q && (pix_index_q == LAST_IDX);
  assign rd_data               = rd_data_q;
  assign busy                  = (state_q != ST_IDLE);
  assign load_done             = load_done_q;
  assign stream_done           = stream_done_q;
  assign error                 = error_q;

endmodule

// File: tb/tb_img_buffer_loader.sv
// Bench for img_buffer_loader: a randomized bridge backed by a byte-addressed memory
// model feeds the DUT; a monitor scores reads and streamed pixels against queues.
module tb_img_buffer_loader;

  localparam int W    = 128;
  localparam int AW   = 26;
  localparam int PB   = 8;
  localparam int NPIX = 100;
  localparam int TO   = 16;
  localparam int PPB  = W / PB;
  localparam int NB   = (NPIX + PPB - 1) / PPB;
  localparam int IB   = $clog2(NPIX);

  typedef struct {
    int          idx;
    logic [PB-1:0] data;
    bit          last;
  } pix_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            restream;
  logic [AW-1:0]   base_address;
  logic [AW-1:0]   interface_address;
  logic [W/8-1:0]  interface_byte_enable;
  logic            interface_read;
  logic            interface_acknowledge;
  logic [W-1:0]    interface_read_data;
  logic            pix_valid;
  logic            pix_ready;
  logic [PB-1:0]   pix_data;
  logic [IB-1:0]   pix_index;
  logic            pix_last;
  logic [IB-1:0]   rd_addr;
  logic [PB-1:0]   rd_data;
  logic            busy;
  logic            load_done;
  logic            stream_done;
  logic            error;

  pix_t          exp_pix[$];
  logic [AW-1:0] exp_addr[$];
  logic [PB-1:0] model_img [NPIX];
  bit            model_valid = 1'b0;
  bit            model_busy  = 1'b0;
  int            checks      = 0;
  int            errors      = 0;
  int            read_cycles = 0;
  int            accept_cnt  = 0;
  logic [7:0]    salt        = 8'h00;
  int            dmin        = 3;
  int            dmax        = 3;
  bit            bridge_mute = 1'b0;
  int            ready_mode  = 0;

  img_buffer_loader #(
    .INTERFACE_WIDTH_BITS(W),
    .INTERFACE_ADDR_BITS (AW),
    .PIXEL_BITS          (PB),
    .NUM_PIXELS          (NPIX),
    .TIMEOUT_CYCLES      (TO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .restream             (restream),
    .base_address         (base_address),
    .interface_address    (interface_address),
    .interface_byte_enable(interface_byte_enable),
    .interface_read       (interface_read),
    .interface_acknowledge(interface_acknowledge),
    .interface_read_data  (interface_read_data),
    .pix_valid            (pix_valid),
    .pix_ready            (pix_ready),
    .pix_data             (pix_data),
    .pix_index            (pix_index),
    .pix_last             (pix_last),
    .rd_addr              (rd_addr),
    .rd_data              (rd_data),
    .busy                 (busy),
    .load_done            (load_done),
    .stream_done          (stream_done),
    .error                (error)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s (no matching expectation or bound expired)", name);
  endtask

  // Memory model: the byte at address a holds a[7:0] ^ salt.
  function automatic logic [W-1:0] beatData(input logic [AW-1:0] a);
    logic [W-1:0] d;
    logic [7:0]   b;
    d = '0;
    for (int j = 0; j < W / 8; j++) begin
      b = a[7:0] + 8'(j);
      d[j*8 +: 8] = b ^ salt;
    end
    return d;
  endfunction

  task automatic applyStimulus(input bit s, input bit r, input logic [AW-1:0] b);
    pix_t p;
    @(posedge clk); #1;
    start        = s;
    restream     = r;
    base_address = b;
    if (!model_busy) begin
      if (s) begin
        for (int k = 0; k < NB; k++) exp_addr.push_back(b + AW'(k * (W / 8)));
        for (int i = 0; i < NPIX; i++) begin
          p.idx  = i;
          p.data = 8'(b + AW'(i)) ^ salt;
          p.last = (i == NPIX - 1);
          model_img[i] = p.data;
          exp_pix.push_back(p);
        end
        model_valid = 1'b1;
        model_busy  = 1'b1;
      end else if (r && model_valid) begin
        for (int i = 0; i < NPIX; i++) begin
          p.idx  = i;
          p.data = model_img[i];
          p.last = (i == NPIX - 1);
          exp_pix.push_back(p);
        end
        model_busy = 1'b1;
      end
    end
    @(posedge clk); #1;
    start    = 1'b0;
    restream = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_pix.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      failNow({tag, "_wait_bound"});
      exp_pix.delete();
    end
    checkOutput({tag, "_reads_left"}, 32'(exp_addr.size()), 32'd0);
    exp_addr.delete();
    repeat (2) @(posedge clk);
    #1;
    model_busy = 1'b0;
  endtask

  // Bridge: acknowledges each read after a random delay; spurious acks while idle.
  initial begin : bridge
    bit pending;
    int wcnt;
    int target;
    pending = 1'b0;
    wcnt    = 0;
    target  = 0;
    interface_acknowledge = 1'b0;
    interface_read_data   = '0;
    forever begin
      @(posedge clk); #1;
      interface_acknowledge = 1'b0;
      interface_read_data   = {$urandom, $urandom, $urandom, $urandom};
      if (interface_read) begin
        if (!pending) begin
          pending = 1'b1;
          wcnt    = 0;
          target  = $urandom_range(dmax, dmin);
        end
        if (!bridge_mute) begin
          if (wcnt >= target) begin
            interface_acknowledge = 1'b1;
            interface_read_data   = beatData(interface_address);
            pending = 1'b0;
          end else begin
            wcnt++;
          end
        end
      end else begin
        pending = 1'b0;
        if ($urandom_range(0, 7) == 0) interface_acknowledge = 1'b1;
      end
    end
  end

  initial begin : consumer
    logic [3:0] pat;
    int rcnt;
    pat  = 4'b1001;
    rcnt = 0;
    pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       begin pix_ready = pat[rcnt % 4]; rcnt++; end
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    bit            ld_exp, sd_exp, ld_nxt, sd_nxt, stall_prev;
    logic [PB-1:0] data_prev;
    logic [IB-1:0] idx_prev;
    logic [AW-1:0] a;
    pix_t          p;
    ld_exp = 1'b0;
    sd_exp = 1'b0;
    stall_prev = 1'b0;
    data_prev = '0;
    idx_prev  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ld_exp     = 1'b0;
        sd_exp     = 1'b0;
        stall_prev = 1'b0;
      end else begin
        ld_nxt = 1'b0;
        sd_nxt = 1'b0;
        if (load_done || ld_exp) checkOutput("load_done", 32'(load_done), 32'(ld_exp));
        if (stream_done || sd_exp) checkOutput("stream_done", 32'(stream_done), 32'(sd_exp));
        if (interface_read) read_cycles++;
        if (interface_read && interface_acknowledge) begin
          if (exp_addr.size() == 0) failNow("unexpected_read");
          else begin
            a = exp_addr.pop_front();
            checkOutput("read_addr", 32'(interface_address), 32'(a));
            ld_nxt = (exp_addr.size() == 0);
          end
        end
        if (stall_prev && pix_valid) begin
          checkOutput("hold_data", 32'(pix_data), 32'(data_prev));
          checkOutput("hold_index", 32'(pix_index), 32'(idx_prev));
        end
        if (pix_valid && pix_ready) begin
          accept_cnt++;
          if (exp_pix.size() == 0) failNow("unexpected_pixel");
          else begin
            p = exp_pix.pop_front();
            checkOutput("pix_data", 32'(pix_data), 32'(p.data));
            checkOutput("pix_index", 32'(pix_index), 32'(p.idx));
            checkOutput("pix_last", 32'(pix_last), 32'(p.last));
            sd_nxt = p.last;
          end
        end
        stall_prev = pix_valid && !pix_ready;
        data_prev  = pix_data;
        idx_prev   = pix_index;
        ld_exp     = ld_nxt;
        sd_exp     = sd_nxt;
      end
    end
  end

  initial begin : watchdog
    #500000;
    failNow("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    int n, ra, rc0, ac0;
    reset        = 1'b1;
    start        = 1'b0;
    restream     = 1'b0;
    base_address = '0;
    rd_addr      = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_read", 32'(interface_read), 32'd0);
    checkOutput("rst_addr", 32'(interface_address), 32'd0);
    checkOutput("rst_be", 32'(&interface_byte_enable), 32'd1);
    checkOutput("rst_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_last", 32'(pix_last), 32'd0);
    checkOutput("rst_index", 32'(pix_index), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_load_done", 32'(load_done), 32'd0);
    checkOutput("rst_stream_done", 32'(stream_done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    reset = 1'b0;

    $display("[TB] first load, base 0x1000, fixed ack delay");
    applyStimulus(1'b1, 1'b0, 26'h0001000);
    waitDone(3000, "load1");
    checkOutput("load1_error", 32'(error), 32'd0);

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ra = $urandom_range(0, NPIX - 1);
      rd_addr = IB'(ra);
      @(posedge clk); #1;
      checkOutput("rd_data", 32'(rd_data), 32'(model_img[ra]));
    end

    $display("[TB] restream with ready pattern 1,0,0,1");
    rc0 = read_cycles;
    ac0 = accept_cnt;
    ready_mode = 1;
    applyStimulus(1'b0, 1'b1, '0);
    waitDone(3000, "restream");
    checkOutput("restream_reads", 32'(read_cycles - rc0), 32'd0);
    checkOutput("restream_accepts", 32'(accept_cnt - ac0), 32'(NPIX));

    $display("[TB] zero-wait latency");
    dmin = 0; dmax = 0; ready_mode = 0; salt = 8'($urandom);
    applyStimulus(1'b1, 1'b0, AW'($urandom));
    n = 1;
    while (!load_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("load_latency", 32'(n), 32'(2 * NB));
    checkOutput("valid_at_load_done", 32'(pix_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("first_valid", 32'(pix_valid), 32'd1);
    waitDone(3000, "latency");

    $display("[TB] address wrap with ignored start/restream mid-load");
    dmin = 0; dmax = 5; ready_mode = 2; salt = 8'($urandom);
    applyStimulus(1'b1, 1'b0, 26'h3FFFFF8);
    repeat (4) @(posedge clk);
    applyStimulus(1'b1, 1'b1, 26'h0000123);
    waitDone(3000, "wrap");

    $display("[TB] timeout");
    bridge_mute = 1'b1;
    rc0 = read_cycles;
    applyStimulus(1'b1, 1'b0, 26'h0002000);
    repeat (TO + 4) @(posedge clk);
    #1;
    checkOutput("to_read", 32'(interface_read), 32'd0);
    checkOutput("to_error", 32'(error), 32'd1);
    checkOutput("to_busy", 32'(busy), 32'd0);
    checkOutput("to_read_cycles", 32'(read_cycles - rc0), 32'(TO));
    exp_addr.delete();
    exp_pix.delete();
    model_valid = 1'b0;
    model_busy  = 1'b0;
    applyStimulus(1'b0, 1'b1, '0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("to_restream_busy", 32'(busy), 32'd0);
    checkOutput("to_error_held", 32'(error), 32'd1);
    bridge_mute = 1'b0;
    salt = 8'($urandom);
    applyStimulus(1'b1, 1'b0, 26'h0004000);
    checkOutput("error_cleared", 32'(error), 32'd0);
    waitDone(3000, "after_to");

    for (int it = 0; it < 3; it++) begin
      dmin = 0; dmax = 4; ready_mode = 2;
      if (it == 1) applyStimulus(1'b0, 1'b1, '0);
      else begin
        salt = 8'($urandom);
        applyStimulus(1'b1, 1'b0, AW'($urandom));
      end
      waitDone(3000, "random");
    end

    $display("[TB] start and restream together in idle");
    salt = 8'($urandom);
    applyStimulus(1'b1, 1'b1, AW'($urandom));
    waitDone(3000, "start_wins");

    $display("[TB] reset mid-load");
    dmin = 2; dmax = 2;
    applyStimulus(1'b1, 1'b0, 26'h0008000);
    n = 0;
    while (exp_addr.size() > NB - 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) failNow("reset_wait_bound");
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rst_read", 32'(interface_read), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_valid", 32'(pix_valid), 32'd0);
    reset = 1'b0;
    exp_addr.delete();
    exp_pix.delete();
    model_valid = 1'b0;
    model_busy  = 1'b0;
    applyStimulus(1'b0, 1'b1, '0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("mid_rst_restream_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
